core_writeback: RTL and testbench

- Write-side master of the integer register file.
- Accepts completed results from the ALU and the load/store unit, arbitrates between them and drives the register-file write port (WADDR/WE/WDATA) and the PC write port (PC_WE/PC_WDATA).
- Maintains a destination-busy scoreboard that decode uses for RAW stall decisions.
- Sits between the execute/LSU stages and the register file.

---
 rtl/core_writeback_pkg.sv | 23 ++
 rtl/core_writeback_if.sv | 46 ++++
 rtl/core_wb_scoreboard.sv | 37 +++
 rtl/core_writeback.sv | 142 ++++++++++++++
 tb/tb_core_writeback.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_writeback_pkg.sv
// Shared definitions for the writeback slice: register-file geometry,
// default data width and the writeback request record.
package core_writeback_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One candidate write to the register file (and optionally the PC).
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  pc_we;
    logic [XLEN-1:0]       pc_data;
  } wb_req_t;

  // One-hot mask selecting register r in a NUM_REGS-wide vector.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/core_writeback_if.sv
// Result/commit bus between the execute stages, the writeback block and
// the register file.
//
// Handshake: a source transfers in a cycle where *_VALID && *_READY. The
// source holds VALID, RD and DATA stable until that cycle. READY is a
// combinational function of the VALIDs and may not feed back into them.
interface core_writeback_if #(
  parameter int XLEN = core_writeback_pkg::XLEN
);
  import core_writeback_pkg::*;

  logic                  ALU_VALID;
  logic                  ALU_READY;
  logic [REG_ADDR_W-1:0] ALU_RD;
  logic [XLEN-1:0]       ALU_DATA;
  logic                  ALU_PC_WE;
  logic [XLEN-1:0]       ALU_PC_DATA;

  logic                  LSU_VALID;
  logic                  LSU_READY;
  logic [REG_ADDR_W-1:0] LSU_RD;
  logic [XLEN-1:0]       LSU_DATA;

  logic [REG_ADDR_W-1:0] WADDR;
  logic                  WE;
  logic [XLEN-1:0]       WDATA;
  logic                  PC_WE;
  logic [XLEN-1:0]       PC_WDATA;

  // Writeback side: consumes results, drives the write ports.
  modport master (
    input  ALU_VALID, ALU_RD, ALU_DATA, ALU_PC_WE, ALU_PC_DATA,
    input  LSU_VALID, LSU_RD, LSU_DATA,
    output ALU_READY, LSU_READY,
    output WADDR, WE, WDATA, PC_WE, PC_WDATA
  );

  // Execute/LSU/register-file side.
  modport slave (
    output ALU_VALID, ALU_RD, ALU_DATA, ALU_PC_WE, ALU_PC_DATA,
    output LSU_VALID, LSU_RD, LSU_DATA,
    input  ALU_READY, LSU_READY,
    input  WADDR, WE, WDATA, PC_WE, PC_WDATA
  );

endinterface

// File: rtl/core_wb_scoreboard.sv
// Destination-busy vector used by decode for RAW stalls. Per edge the
// committing write clears its bit, then a new issue sets its bit (so set
// wins on a collision); flush overrides both. Register 0 is never busy.
module core_wb_scoreboard
  import core_writeback_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy vector: clear committed, set issued, flush wipes everything.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d = busy_d & ~reg_onehot(clr_addr);
    if (set_en) busy_d = busy_d | reg_onehot(set_addr);
    if (flush)  busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Busy register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/core_writeback.sv
// Writeback stage: arbitrates ALU and LSU results onto the register-file
// and PC write ports and keeps the destination-busy scoreboard.
// LSU normally wins; an ALU result that has lost STARVE_MAX cycles in a
// row is forced through.
// Optional macro WB_BYPASS_EN adds the BYP0/BYP1 forwarding outputs.
module core_writeback
  import core_writeback_pkg::*;
#(
  parameter int XLEN       = core_writeback_pkg::XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FLUSH,
  input  logic                  ISSUE_VALID,
  input  logic [REG_ADDR_W-1:0] ISSUE_RD,
  output logic [NUM_REGS-1:0]   BUSY,
  core_writeback_if.master      wb
`ifdef WB_BYPASS_EN
  ,
  output logic                  BYP0_VALID,
  output logic [REG_ADDR_W-1:0] BYP0_RD,
  output logic [XLEN-1:0]       BYP0_DATA,
  output logic                  BYP1_VALID,
  output logic [REG_ADDR_W-1:0] BYP1_RD,
  output logic [XLEN-1:0]       BYP1_DATA
`endif
);

  logic [3:0]            starve_cnt;
  logic                  alu_force;
  logic                  alu_ready;
  logic                  lsu_ready;
  wb_req_t               sel;

  logic                  we_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  pc_we_q;
  logic [XLEN-1:0]       pc_wdata_q;

  assign alu_force = (starve_cnt >= 4'(STARVE_MAX));

  // Arbitration: LSU first unless the ALU has starved; nothing while in reset.
  always_comb begin
    lsu_ready = RST_N && wb.LSU_VALID && !alu_force;
    alu_ready = RST_N && wb.ALU_VALID && (!wb.LSU_VALID || alu_force);
  end

  assign wb.ALU_READY = alu_ready;
  assign wb.LSU_READY = lsu_ready;

  // Pick the accepted result; LSU results never redirect the PC.
  always_comb begin
    sel = '0;
    if (alu_ready) begin
      sel.valid   = 1'b1;
      sel.rd      = wb.ALU_RD;
      sel.data    = wb.ALU_DATA;
      sel.pc_we   = wb.ALU_PC_WE;
      sel.pc_data = wb.ALU_PC_DATA;
    end else if (lsu_ready) begin
      sel.valid   = 1'b1;
      sel.rd      = wb.LSU_RD;
      sel.data    = wb.LSU_DATA;
    end
  end

  // Lost-arbitration counter: counts while the ALU waits, saturates at 15.
  always_ff @(posedge CLK) begin
    if (!RST_N)                        starve_cnt <= '0;
    else if (wb.ALU_VALID && !alu_ready) begin
      if (starve_cnt != 4'hf)          starve_cnt <= starve_cnt + 4'd1;
    end else                           starve_cnt <= '0;
  end

  // Output stage: one-cycle pulses for WE/PC_WE, address/data hold when idle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pc_we_q    <= 1'b0;
      pc_wdata_q <= '0;
    end else begin
      we_q    <= sel.valid && (sel.rd != '0);
      pc_we_q <= sel.valid && sel.pc_we;
      if (sel.valid) begin
        waddr_q <= sel.rd;
        wdata_q <= sel.data;
      end
      if (sel.valid && sel.pc_we) pc_wdata_q <= sel.pc_data;
    end
  end

  assign wb.WE       = we_q;
  assign wb.WADDR    = waddr_q;
  assign wb.WDATA    = wdata_q;
  assign wb.PC_WE    = pc_we_q;
  assign wb.PC_WDATA = pc_wdata_q;

  // Issue is ignored during a flush; the committing write clears its bit.
  core_wb_scoreboard u_scoreboard (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr_en   (we_q),
    .clr_addr (waddr_q),
    .set_en   (ISSUE_VALID),
    .set_addr (ISSUE_RD),
    .flush    (FLUSH),
    .busy     (BUSY)
  );

`ifdef WB_BYPASS_EN
  logic                  byp1_valid_q;
  logic [REG_ADDR_W-1:0] byp1_rd_q;
  logic [XLEN-1:0]       byp1_data_q;

  // Stage 0 is the write being committed now; we_q is already 0 for x0.
  assign BYP0_VALID = we_q;
  assign BYP0_RD    = waddr_q;
  assign BYP0_DATA  = wdata_q;

  // Stage 1 covers the cycle after commit, while the RF read is still stale.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      byp1_valid_q <= 1'b0;
      byp1_rd_q    <= '0;
      byp1_data_q  <= '0;
    end else begin
      byp1_valid_q <= we_q && (waddr_q != '0);
      byp1_rd_q    <= waddr_q;
      byp1_data_q  <= wdata_q;
    end
  end

  assign BYP1_VALID = byp1_valid_q;
  assign BYP1_RD    = byp1_rd_q;
  assign BYP1_DATA  = byp1_data_q;
`endif

endmodule

// File: tb/tb_core_writeback.sv
// Directed and random stimulus for core_writeback with a reference model
// of arbitration, output registers and scoreboard; expected outputs are
// queued when stimulus is applied and compared after the clock edge.
module tb_core_writeback;
  import core_writeback_pkg::*;

  localparam int XW = 32;
  localparam int SM = 4;
  localparam int OW = 1 + 5 + XW + 1 + XW;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        FLUSH = 1'b0;
  logic        ISSUE_VALID = 1'b0;
  logic [4:0]  ISSUE_RD = '0;
  logic [31:0] BUSY;

`ifdef WB_BYPASS_EN
  logic          byp0_valid, byp1_valid;
  logic [4:0]    byp0_rd, byp1_rd;
  logic [XW-1:0] byp0_data, byp1_data;
`endif

  core_writeback_if #(.XLEN(XW)) bus ();

  core_writeback #(.XLEN(XW), .STARVE_MAX(SM)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .FLUSH       (FLUSH),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_RD    (ISSUE_RD),
    .BUSY        (BUSY),
    .wb          (bus)
`ifdef WB_BYPASS_EN
    ,
    .BYP0_VALID  (byp0_valid),
    .BYP0_RD     (byp0_rd),
    .BYP0_DATA   (byp0_data),
    .BYP1_VALID  (byp1_valid),
    .BYP1_RD     (byp1_rd),
    .BYP1_DATA   (byp1_data)
`endif
  );

  // Clock
  always #5 CLK = ~CLK;

  // Scoreboard and counters
  logic [OW-1:0] exp_q[$];
  int            total = 0;
  int            bad = 0;

  // Reference model state (what the outputs should currently show)
  int            m_starve = 0;
  logic [31:0]   m_busy = '0;
  logic          m_we = 1'b0;
  logic [4:0]    m_waddr = '0;
  logic [XW-1:0] m_wdata = '0;
  logic          m_pcwe = 1'b0;
  logic [XW-1:0] m_pcdata = '0;
  logic          alu_acc = 1'b0;
  logic          lsu_acc = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    bus.ALU_VALID = 1'b0; bus.ALU_RD = '0; bus.ALU_DATA = '0;
    bus.ALU_PC_WE = 1'b0; bus.ALU_PC_DATA = '0;
    bus.LSU_VALID = 1'b0; bus.LSU_RD = '0; bus.LSU_DATA = '0;
    ISSUE_VALID = 1'b0; ISSUE_RD = '0; FLUSH = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [XW-1:0] d,
                           input logic pcwe, input logic [XW-1:0] pcd);
    bus.ALU_VALID = 1'b1; bus.ALU_RD = rd; bus.ALU_DATA = d;
    bus.ALU_PC_WE = pcwe; bus.ALU_PC_DATA = pcd;
  endtask

  task automatic drive_lsu(input logic [4:0] rd, input logic [XW-1:0] d);
    bus.LSU_VALID = 1'b1; bus.LSU_RD = rd; bus.LSU_DATA = d;
  endtask

  // One clock: predict READY and next outputs, queue them, clock, compare.
  task automatic cycle();
    logic          frc, ea, el;
    logic          n_we, n_pcwe;
    logic [4:0]    n_waddr;
    logic [XW-1:0] n_wdata, n_pcdata;
    logic [31:0]   nb;
    logic [OW-1:0] e;
    #1;
    frc = (m_starve >= SM);
    el  = RST_N && bus.LSU_VALID && !frc;
    ea  = RST_N && bus.ALU_VALID && (!bus.LSU_VALID || frc);
    chk("alu_ready", bus.ALU_READY, ea);
    chk("lsu_ready", bus.LSU_READY, el);
    n_we = 1'b0; n_pcwe = 1'b0;
    n_waddr = m_waddr; n_wdata = m_wdata; n_pcdata = m_pcdata;
    nb = m_busy;
    if (!RST_N) begin
      n_waddr = '0; n_wdata = '0; n_pcdata = '0; nb = '0; m_starve = 0;
    end else begin
      if (m_we) nb[m_waddr] = 1'b0;
      if (ISSUE_VALID && ISSUE_RD != 0) nb[ISSUE_RD] = 1'b1;
      if (FLUSH) nb = '0;
      if (ea) begin
        n_we = (bus.ALU_RD != 0); n_waddr = bus.ALU_RD; n_wdata = bus.ALU_DATA;
        n_pcwe = bus.ALU_PC_WE;
        if (bus.ALU_PC_WE) n_pcdata = bus.ALU_PC_DATA;
      end else if (el) begin
        n_we = (bus.LSU_RD != 0); n_waddr = bus.LSU_RD; n_wdata = bus.LSU_DATA;
      end
      if (bus.ALU_VALID && !ea) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
      else                      m_starve = 0;
    end
    alu_acc = ea;
    lsu_acc = el;
    exp_q.push_back({n_we, n_waddr, n_wdata, n_pcwe, n_pcdata});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk("wb_out", {bus.WE, bus.WADDR, bus.WDATA, bus.PC_WE, bus.PC_WDATA}, e);
    chk("busy", BUSY, nb);
    m_we = n_we; m_waddr = n_waddr; m_wdata = n_wdata;
    m_pcwe = n_pcwe; m_pcdata = n_pcdata; m_busy = nb;
  endtask

  initial begin
    idle();

    // Reset held three cycles with both sources valid
    RST_N = 1'b0;
    drive_lsu(5'd1, 32'h0000_00aa);
    drive_alu(5'd2, 32'h0000_00bb, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_we", bus.WE, 1'b0);
    chk("rst_pc_we", bus.PC_WE, 1'b0);
    chk("rst_busy", BUSY, 32'h0);

    // Release: LSU wins first, written one cycle later
    RST_N = 1'b1;
    cycle();
    chk("first_we", bus.WE, 1'b1);
    chk("first_waddr", bus.WADDR, 5'd1);
    idle();
    cycle();

    // Single ALU write to a busy register
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd5;
    cycle();
    idle();
    chk("busy5_set", BUSY, 32'h0000_0020);
    drive_alu(5'd5, 32'hdead_beef, 1'b0, 32'h0);
    cycle();
    idle();
    chk("alu_we", bus.WE, 1'b1);
    chk("alu_waddr", bus.WADDR, 5'd5);
    chk("alu_wdata", bus.WDATA, 32'hdead_beef);
    cycle();
    chk("busy5_clr", BUSY[5], 1'b0);
    chk("idle_we", bus.WE, 1'b0);
    chk("idle_hold", bus.WDATA, 32'hdead_beef);

    // Collision: LSU first, ALU next cycle
    drive_lsu(5'd7, 32'h11);
    drive_alu(5'd8, 32'h22, 1'b0, 32'h0);
    cycle();
    chk("col_lsu", {bus.WADDR, bus.WDATA}, {5'd7, 32'h11});
    bus.LSU_VALID = 1'b0;
    cycle();
    chk("col_alu", {bus.WADDR, bus.WDATA}, {5'd8, 32'h22});
    idle();
    cycle();

    // Starvation: ALU forced through on the fifth cycle
    drive_lsu(5'd11, 32'h1111);
    drive_alu(5'd10, 32'h1010, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("starve_waddr", bus.WADDR, (i < 4) ? 5'd11 : 5'd10);
    end
    bus.ALU_VALID = 1'b0;
    cycle();
    chk("starve_resume", bus.WADDR, 5'd11);
    idle();
    cycle();

    // Redirect through x0
    drive_alu(5'd0, 32'h5555, 1'b1, 32'h80);
    cycle();
    idle();
    chk("redir", {bus.WE, bus.PC_WE, bus.PC_WDATA}, {1'b0, 1'b1, 32'h80});
    cycle();
    chk("redir_pulse", bus.PC_WE, 1'b0);

    // Scoreboard race: issue rd9 while rd9 commits
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9;
    cycle();
    idle();
    drive_alu(5'd9, 32'h99, 1'b0, 32'h0);
    cycle();
    idle();
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9;
    cycle();
    idle();
    chk("race_busy9", BUSY[9], 1'b1);

    // Flush with an accepted write in flight
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd12;
    cycle();
    ISSUE_RD = 5'd13;
    cycle();
    idle();
    drive_alu(5'd12, 32'hc12, 1'b0, 32'h0);
    cycle();
    drive_alu(5'd13, 32'hc13, 1'b0, 32'h0);
    FLUSH = 1'b1; ISSUE_VALID = 1'b1; ISSUE_RD = 5'd14;
    cycle();
    idle();
    chk("flush_busy", BUSY, 32'h0);
    chk("flush_we", {bus.WE, bus.WADDR}, {1'b1, 5'd13});
    cycle();

    // Mid-operation reset
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd20;
    cycle();
    idle();
    drive_alu(5'd20, 32'h2020, 1'b1, 32'h100);
    RST_N = 1'b0;
    cycle();
    chk("midrst", {bus.WE, bus.PC_WE, BUSY}, {1'b0, 1'b0, 32'h0});
    RST_N = 1'b1;
    idle();
    cycle();

    // Random traffic with hold-until-accepted sources
    alu_acc = 1'b0; lsu_acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.ALU_VALID || alu_acc) begin
        bus.ALU_VALID   = ($urandom_range(0, 3) != 0);
        bus.ALU_RD      = 5'($urandom_range(0, 31));
        bus.ALU_DATA    = $urandom;
        bus.ALU_PC_WE   = ($urandom_range(0, 3) == 0);
        bus.ALU_PC_DATA = $urandom;
      end
      if (!bus.LSU_VALID || lsu_acc) begin
        bus.LSU_VALID = ($urandom_range(0, 3) != 0);
        bus.LSU_RD    = 5'($urandom_range(0, 31));
        bus.LSU_DATA  = $urandom;
      end
      ISSUE_VALID = ($urandom_range(0, 1) == 1);
      ISSUE_RD    = 5'($urandom_range(0, 31));
      FLUSH       = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
